pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning the width of the Length input and the internal counter.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 2, meaning the number of guard cycles after Level falls (legal range 1..2^CNT_W-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port Trigger, input, 1 bit: start request, normally a one-cycle pulse sampled on each clk edge.
REQ-006 SHALL have port Length, input, CNT_W bits: requested high time in cycles, sampled on the accepting edge.
REQ-007 SHALL have port Retrigger_En, input, 1 bit: when high, a Trigger during ACTIVE restarts the count.
REQ-008 SHALL have port Level, output, 1 bit: the stretched output pulse.
REQ-009 SHALL have port Busy, output, 1 bit: high in ACTIVE or HOLDOFF.
REQ-010 SHALL have port Done, output, 1 bit: one-cycle pulse marking completion.
REQ-011 SHALL have port Missed, output, 1 bit: one-cycle pulse flagging an ignored Trigger.

Function
REQ-012 SHALL implement three states: IDLE, ACTIVE, HOLDOFF.
REQ-013 SHALL drive all outputs from registers, with no combinational path from any input to any output.
REQ-014 IDLE: on Trigger=1 and Length!=0, SHALL go to ACTIVE and load the counter with Length.
REQ-015 IDLE: on Trigger=1 and Length=0, SHALL stay in IDLE and pulse Missed in the next cycle.
REQ-016 Level SHALL be 1 exactly while in ACTIVE; for an accept at edge k, Level is high for cycles k+1 through k+Length (exactly Length cycles).
REQ-017 ACTIVE: with counter>1, SHALL decrement; with counter=1, SHALL go to HOLDOFF and load the counter with HOLDOFF_CYCLES.
REQ-018 ACTIVE: on Trigger=1, Retrigger_En=1 and Length!=0, SHALL reload the counter with Length and stay in ACTIVE; this has priority over the counter=1 exit, and no Done is issued.
REQ-019 ACTIVE: on Trigger=1 with Retrigger_En=0 or Length=0, SHALL ignore the Trigger, keep counting, and pulse Missed in the next cycle.
REQ-020 Done SHALL be high for exactly one cycle: the first HOLDOFF cycle, immediately after the last Level-high cycle.
REQ-021 HOLDOFF: SHALL hold Level=0 and Busy=1 for exactly HOLDOFF_CYCLES cycles, then go to IDLE.
REQ-022 HOLDOFF: any Trigger SHALL be ignored and SHALL pulse Missed in the next cycle.
REQ-023 A Trigger held high SHALL be treated as one request per cycle; with Retrigger_En=1, Level then stays high until Length cycles after Trigger falls.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 1; Length=2^CNT_W-1 yields 2^CNT_W-1 high cycles.
REQ-025 An illegal state encoding SHALL recover to IDLE on the next edge, with all outputs low.

Reset
REQ-026 With reset=0 at a rising clk edge, the block SHALL enter IDLE, clear the counter, and drive Level=0, Busy=0, Done=0, Missed=0 from the next cycle.
REQ-027 Reset asserted mid-ACTIVE or mid-HOLDOFF SHALL abort without issuing Done or Missed.
REQ-028 A Trigger sampled on the same edge as reset=0 SHALL be discarded.

Structure
REQ-029 The state enum typedef (IDLE, ACTIVE, HOLDOFF, 2-bit logic) SHALL live in the shared package pulse_pkg.
REQ-030 The loadable down-counter (load value, load enable, decrement, is-one flag) SHALL be the sub-module down_counter, parameterised by CNT_W.

Verification
REQ-031 With Length=5 and a Trigger pulse at edge 10: Level high cycles 11-15, Done at 16, Busy high 11-17, IDLE at 18 (HOLDOFF_CYCLES=2).
REQ-032 With Length=4, Retrigger_En=1, Triggers at edges 10 and 12: Level high cycles 11-16, a single Done at 17, no Missed.
REQ-033 With Length=4, Retrigger_En=0, Triggers at edges 10 and 12: Level high 11-14, Missed at 13, Done at 15.
REQ-034 With Length=0 and a Trigger in IDLE: Missed for one cycle, Level and Busy stay 0; a Trigger during HOLDOFF also gives Missed only.
REQ-035 With Length=8, Trigger at edge 10 and reset=0 at edge 13: Level low from cycle 14, no Done, and a fresh Trigger at edge 15 is accepted normally.
REQ-036 With CNT_W=8, Length=255: exactly 255 Level-high cycles, then one Done.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse stretcher slice.
package pulse_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 8;
  localparam int unsigned HOLDOFF_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Request/response bundle between the pulse stretcher and its requester.
interface pulse_stretcher_if
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             trigger;
  logic [CNT_W-1:0] length;
  logic             retrigger_en;
  logic             level;
  logic             busy;
  logic             done;
  logic             missed;

  modport master (
    output trigger, length, retrigger_en,
    input  level, busy, done, missed
  );

  modport slave (
    input  trigger, length, retrigger_en,
    output level, busy, done, missed
  );

endinterface

// File: rtl/pulse_stretcher_core.sv
// Stretcher FSM: IDLE -> ACTIVE (Length cycles) -> HOLDOFF (guard) -> IDLE.
module pulse_stretcher_core
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  pulse_stretcher_if.slave   bus
);

  state_e           state_q;
  logic             level_q;
  logic             busy_q;
  logic             done_q;
  logic             missed_q;

  logic             len_ok_c;
  logic             accept_c;
  logic             retrig_c;
  logic             cnt_load_c;
  logic [CNT_W-1:0] cnt_val_c;
  logic             cnt_dec_c;
  logic             cnt_is_one_c;

  assign len_ok_c = (bus.length != '0);
  assign accept_c = bus.trigger && len_ok_c;
  assign retrig_c = accept_c && bus.retrigger_en;

  // Counter control: a retrigger reload takes priority over the ACTIVE exit.
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_val_c  = bus.length;
    cnt_dec_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_load_c = accept_c;
      end
      ACTIVE: begin
        if (retrig_c) begin
          cnt_load_c = 1'b1;
        end else if (cnt_is_one_c) begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(HOLDOFF_CYCLES);
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      HOLDOFF: begin
        cnt_dec_c = 1'b1;
      end
      default: begin
        cnt_load_c = 1'b0;
      end
    endcase
  end

  down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_en_i  (cnt_load_c),
    .load_val_i (cnt_val_c),
    .dec_i      (cnt_dec_c),
    .is_one_c_o (cnt_is_one_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          level_q <= 1'b0;
          busy_q  <= 1'b0;
          if (accept_c) begin
            state_q <= ACTIVE;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (bus.trigger) begin
            missed_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!retrig_c) begin
            missed_q <= bus.trigger;
            if (cnt_is_one_c) begin
              state_q <= HOLDOFF;
              level_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        HOLDOFF: begin
          missed_q <= bus.trigger;
          if (cnt_is_one_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level  = level_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.missed = missed_q;

endmodule

// File: rtl/pulse_stretcher_down_counter.sv
// Loadable down-counter that saturates at 1 and flags when it holds 1.
module down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_one_c_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; decrement never goes below 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_c_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher top: maps the flat port list onto the bundle seen by the core.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Trigger,
  input  logic [CNT_W-1:0] Length,
  input  logic             Retrigger_En,
  output logic             Level,
  output logic             Busy,
  output logic             Done,
  output logic             Missed
);

  pulse_stretcher_if #(.CNT_W(CNT_W)) bus_if ();

  assign bus_if.trigger      = Trigger;
  assign bus_if.length       = Length;
  assign bus_if.retrigger_en = Retrigger_En;

  pulse_stretcher_core #(
    .CNT_W          (CNT_W),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  assign Level  = bus_if.level;
  assign Busy   = bus_if.busy;
  assign Done   = bus_if.done;
  assign Missed = bus_if.missed;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: per-cycle expected outputs queued by the
// stimulus, popped and compared by an independent monitor.
module tb_pulse_stretcher;
  import pulse_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned HOLD  = 2;

  logic clk = 1'b0;
  logic reset;

  pulse_stretcher_if #(.CNT_W(CNT_W)) bus ();

  pulse_stretcher #(
    .CNT_W          (CNT_W),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Trigger      (bus.trigger),
    .Length       (bus.length),
    .Retrigger_En (bus.retrigger_en),
    .Level        (bus.level),
    .Busy         (bus.busy),
    .Done         (bus.done),
    .Missed       (bus.missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         tag;
    int         c;
    logic [3:0] v;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: outputs of cycle c are sampled at the falling edge after rising edge c-1.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act;
    while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
      e   = sb_q.pop_front();
      act = {bus.level, bus.busy, bus.done, bus.missed};
      checks++;
      if (e.tag != cyc || act !== e.v) begin
        failures++;
        $display("FAIL %s cycle %0d: level/busy/done/missed got %b expected %b",
                 e.name, e.c, act, e.v);
      end
    end
  end

  function automatic bit in_rng(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  // Edges are numbered from the start of the test; reset is held on edges 1-2.
  // Triggers: held on edges ta..tb plus single edge tc. rs: extra reset edge.
  task automatic run(input string nm, input int len, input bit ret,
                     input int ta, input int tb, input int tc, input int rs,
                     input int la, input int lb, input int lc, input int ld,
                     input int ba, input int bb, input int bc, input int bd,
                     input int dn, input int ms, input int last);
    int   base;
    exp_t e;
    base = cyc;
    for (int c = 2; c <= last; c++) begin
      e.tag  = base + c - 1;
      e.c    = c;
      e.name = nm;
      e.v    = {in_rng(c, la, lb) || in_rng(c, lc, ld),
                in_rng(c, ba, bb) || in_rng(c, bc, bd),
                c == dn, c == ms};
      sb_q.push_back(e);
    end
    bus.length       = CNT_W'(len);
    bus.retrigger_en = ret;
    for (int k = 1; k <= last; k++) begin
      reset       = !(k <= 2 || k == rs);
      bus.trigger = in_rng(k, ta, tb) || (k == tc);
      @(negedge clk);
    end
    bus.trigger = 1'b0;
    reset       = 1'b1;
  endtask

  initial begin
    reset            = 1'b0;
    bus.trigger      = 1'b0;
    bus.length       = '0;
    bus.retrigger_en = 1'b0;
    repeat (3) @(negedge clk);

    //   name           len ret  ta  tb  tc  rs   la  lb  lc  ld   ba  bb  bc  bd   done miss last
    run("basic_len5",     5, 0, 10, 10, -1, -1, 11, 15, -1, -1, 11, 17, -1, -1,  16,  -1, 22);
    run("retrig_len4",    4, 1, 10, 10, 12, -1, 11, 16, -1, -1, 11, 18, -1, -1,  17,  -1, 22);
    run("noretrig_len4",  4, 0, 10, 10, 12, -1, 11, 14, -1, -1, 11, 16, -1, -1,  15,  13, 22);
    run("len0_idle",      0, 0, 10, 10, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,  -1,  11, 16);
    run("holdoff_trig",   3, 1, 10, 10, 14, -1, 11, 13, -1, -1, 11, 15, -1, -1,  14,  15, 20);
    run("reset_abort",    8, 0, 10, 10, 15, 13, 11, 13, 16, 23, 11, 13, 16, 25,  24,  -1, 30);
    run("trig_on_reset",  4, 0, 10, 10, -1, 10, -1, -1, -1, -1, -1, -1, -1, -1,  -1,  -1, 16);
    run("len1",           1, 0, 10, 10, -1, -1, 11, 11, -1, -1, 11, 13, -1, -1,  12,  -1, 18);
    run("retrig_at_one",  2, 1, 10, 10, 12, -1, 11, 14, -1, -1, 11, 16, -1, -1,  15,  -1, 20);
    run("held_trigger",   3, 1, 10, 13, -1, -1, 11, 16, -1, -1, 11, 18, -1, -1,  17,  -1, 22);
    run("len255",       255, 0, 10, 10, -1, -1, 11, 265, -1, -1, 11, 267, -1, -1, 266, -1, 272);

    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
